// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master to one-slave valid/ready memory bus arbiter (define ARB_RR_EN for round-robin)
module mem_arbiter #(
    parameter bit PRIO_M1 = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic        owner
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t      r_state;
    logic        r_s_valid;
    logic        r_owner;
    logic        r_m0_ready;
    logic        r_m1_ready;
    logic [31:0] r_s_addr;
    logic [31:0] r_s_wdata;
    logic [3:0]  r_s_wstrb;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        w_win;
`ifdef ARB_RR_EN
    logic        r_last;
    // on a tie the master not granted last wins
    assign w_win = (m0_valid & m1_valid) ? ~r_last : m1_valid;
`else
    // on a tie the fixed-priority master wins
    assign w_win = (m0_valid & m1_valid) ? PRIO_M1 : m1_valid;
`endif
    assign s_valid  = r_s_valid;
    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign s_wstrb  = r_s_wstrb;
    assign owner    = r_owner;
    assign m0_ready = r_m0_ready;
    assign m1_ready = r_m1_ready;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    // grant, hold the request until the slave completes, then pulse the owner's ready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_s_valid  <= 1'b0;
            r_owner    <= 1'b0;
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
            r_s_addr   <= '0;
            r_s_wdata  <= '0;
            r_s_wstrb  <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
`ifdef ARB_RR_EN
            r_last     <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: if (m0_valid | m1_valid) begin
                    r_owner   <= w_win;
                    r_s_addr  <= w_win ? m1_addr  : m0_addr;
                    r_s_wdata <= w_win ? m1_wdata : m0_wdata;
                    r_s_wstrb <= w_win ? m1_wstrb : m0_wstrb;
                    r_s_valid <= 1'b1;
                    r_state   <= BUSY;
                end
                BUSY: if (s_ready) begin
                    r_s_valid <= 1'b0;
                    if (r_owner) begin
                        r_m1_rdata <= s_rdata;
                        r_m1_ready <= 1'b1;
                    end else begin
                        r_m0_rdata <= s_rdata;
                        r_m0_ready <= 1'b1;
                    end
`ifdef ARB_RR_EN
                    r_last    <= r_owner;
`endif
                    r_state   <= RESP;
                end
                RESP: begin
                    r_m0_ready <= 1'b0;
                    r_m1_ready <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a one-cycle-latency RAM slave model
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready, owner;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        auto_ready = 1'b0, stray_ready = 1'b0, loaded = 1'b0;
    logic [31:0] mem [16];
    logic [31:0] w;
    int          total = 0, bad = 0;
    int          rdy0 = 0, rdy1 = 0, cyc = 0;
    logic        prev_sv = 1'b0;
    logic        owners [$];
    int          rise_cyc [$];

    mem_arbiter #(.PRIO_M1(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    assign s_ready = auto_ready | stray_ready;

    // RAM slave: answers one cycle after seeing s_valid, applying byte strobes
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[4] <= 32'hCAFEF00D;
            mem[8] <= 32'hFFFFFFFF;
            loaded <= 1'b1;
        end else if (auto_ready) begin
            auto_ready <= 1'b0;
        end else if (s_valid) begin
            w = mem[s_addr[5:2]];
            for (int b = 0; b < 4; b++) if (s_wstrb[b]) w[8*b +: 8] = s_wdata[8*b +: 8];
            mem[s_addr[5:2]] <= w;
            s_rdata <= w;
            auto_ready <= 1'b1;
        end
    end

    // bus monitor: grant edges, granted owner and ready pulse counts
    always @(posedge clk) begin
        #2;
        cyc++;
        if (s_valid && !prev_sv) begin
            owners.push_back(owner);
            rise_cyc.push_back(cyc);
        end
        prev_sv = s_valid;
        if (m0_ready) rdy0++;
        if (m1_ready) rdy1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit m, input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (m) begin
            m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
        end else begin
            m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
        end
    endtask

    task automatic txn(input string tag, input bit m, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_rd);
        drive(m, 1'b1, a, d, s);
        tick;
        chk({tag, "_svalid"}, {31'b0, s_valid}, 32'd1);
        chk({tag, "_saddr"}, s_addr, a);
        chk({tag, "_swdata"}, s_wdata, d);
        chk({tag, "_swstrb"}, {28'b0, s_wstrb}, {28'b0, s});
        chk({tag, "_owner"}, {31'b0, owner}, {31'b0, m});
        tick;
        tick;
        chk({tag, "_rdy"}, {31'b0, m ? m1_ready : m0_ready}, 32'd1);
        chk({tag, "_other_rdy"}, {31'b0, m ? m0_ready : m1_ready}, 32'd0);
        chk({tag, "_rdata"}, m ? m1_rdata : m0_rdata, exp_rd);
        chk({tag, "_svalid_low"}, {31'b0, s_valid}, 32'd0);
        @(posedge clk);
        #1 drive(m, 1'b0, a, d, s);
        @(negedge clk);
        chk({tag, "_rdy_end"}, {31'b0, m ? m1_ready : m0_ready}, 32'd0);
    endtask

    initial begin
        bit f;
        int base, b0, b1;
        logic [31:0] fa, sa, fd, sd;
        tick;
        tick;
        chk("rst_svalid", {31'b0, s_valid}, 32'd0);
        chk("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
        chk("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
        chk("rst_owner", {31'b0, owner}, 32'd0);
        chk("rst_saddr", s_addr, 32'd0);
        chk("rst_swdata", s_wdata, 32'd0);
        chk("rst_swstrb", {28'b0, s_wstrb}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        resetn = 1'b1;
        tick;

        txn("t1_m0_rd", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hCAFEF00D);
        txn("t2_m1_wr", 1'b1, 32'h20, 32'h11223344, 4'b0101, 32'hFF22FF44);
        txn("t2_m1_rd", 1'b1, 32'h20, 32'h0, 4'b0000, 32'hFF22FF44);
        chk("t2_m0_rdata_hold", m0_rdata, 32'hCAFEF00D);

`ifdef ARB_RR_EN
        f = 1'b0;
`else
        f = 1'b1;
`endif
        fa = f ? 32'h20 : 32'h10;
        sa = f ? 32'h10 : 32'h20;
        fd = f ? 32'hFF22FF44 : 32'hCAFEF00D;
        sd = f ? 32'hCAFEF00D : 32'hFF22FF44;
        base = rise_cyc.size();
        drive(1'b0, 1'b1, 32'h10, 32'h0, 4'b0000);
        drive(1'b1, 1'b1, 32'h20, 32'h0, 4'b0000);
        tick;
        chk("t3_first_owner", {31'b0, owner}, {31'b0, f});
        chk("t3_first_addr", s_addr, fa);
        tick;
        tick;
        chk("t3_first_rdy", {31'b0, f ? m1_ready : m0_ready}, 32'd1);
        chk("t3_loser_rdy", {31'b0, f ? m0_ready : m1_ready}, 32'd0);
        chk("t3_first_rdata", f ? m1_rdata : m0_rdata, fd);
        @(posedge clk);
        #1 drive(f, 1'b0, fa, 32'h0, 4'b0000);
        @(negedge clk);
        tick;
        chk("t3_second_svalid", {31'b0, s_valid}, 32'd1);
        chk("t3_second_owner", {31'b0, owner}, {31'b0, ~f});
        chk("t3_second_addr", s_addr, sa);
        tick;
        tick;
        chk("t3_second_rdy", {31'b0, f ? m0_ready : m1_ready}, 32'd1);
        chk("t3_second_rdata", f ? m0_rdata : m1_rdata, sd);
        @(posedge clk);
        #1 drive(~f, 1'b0, sa, 32'h0, 4'b0000);
        tick;
        tick;
        chk("t3_rises", rise_cyc.size() - base, 32'd2);
        chk("t3_gap", rise_cyc[base + 1] - rise_cyc[base], 32'd4);

        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        tick;
        base = owners.size();
        b0 = rdy0;
        b1 = rdy1;
        drive(1'b0, 1'b1, 32'h10, 32'h0, 4'b0000);
        drive(1'b1, 1'b1, 32'h20, 32'h0, 4'b0000);
        for (int i = 0; i < 60 && owners.size() < base + 8; i++) tick;
        drive(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000);
        drive(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000);
        for (int i = 0; i < 6; i++) tick;
        chk("t4_grants", owners.size() - base, 32'd8);
        for (int i = 0; i < 8; i++) begin
`ifdef ARB_RR_EN
            chk($sformatf("t4_owner%0d", i), {31'b0, owners[base + i]}, i % 2);
`else
            chk($sformatf("t4_owner%0d", i), {31'b0, owners[base + i]}, 32'd1);
`endif
        end
`ifdef ARB_RR_EN
        chk("t4_m0_done", rdy0 - b0, 32'd4);
        chk("t4_m1_done", rdy1 - b1, 32'd4);
`else
        chk("t4_m0_done", rdy0 - b0, 32'd0);
        chk("t4_m1_done", rdy1 - b1, 32'd8);
`endif

        drive(1'b0, 1'b1, 32'h10, 32'h0, 4'b0000);
        tick;
        chk("t5_busy_svalid", {31'b0, s_valid}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("t5_rst_svalid", {31'b0, s_valid}, 32'd0);
        chk("t5_rst_m0_ready", {31'b0, m0_ready}, 32'd0);
        chk("t5_rst_m1_ready", {31'b0, m1_ready}, 32'd0);
        drive(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000);
        b0 = rdy0;
        b1 = rdy1;
        @(negedge clk);
        resetn = 1'b1;
        tick;
        stray_ready = 1'b1;
        tick;
        stray_ready = 1'b0;
        tick;
        tick;
        chk("t5_stray_m0", rdy0 - b0, 32'd0);
        chk("t5_stray_m1", rdy1 - b1, 32'd0);
        chk("t5_stray_svalid", {31'b0, s_valid}, 32'd0);

        base = rise_cyc.size();
        drive(1'b0, 1'b1, 32'h10, 32'h0, 4'b0000);
        for (int i = 0; i < 30 && rise_cyc.size() < base + 3; i++) tick;
        drive(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000);
        for (int i = 0; i < 6; i++) tick;
        chk("t6_grants", rise_cyc.size() - base, 32'd3);
        chk("t6_gap1", rise_cyc[base + 1] - rise_cyc[base], 32'd4);
        chk("t6_gap2", rise_cyc[base + 2] - rise_cyc[base + 1], 32'd4);
        chk("t6_rdata", m0_rdata, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
